// File: rtl/secure_reg_pkg.sv
// rtl/secure_reg_pkg.sv - shared op encoding, FSM states and privileged thread ID
package secure_reg_pkg;

   typedef enum logic [2:0] {
      OP_READ      = 3'd0,
      OP_WRITE     = 3'd1,
      OP_SET_OWNER = 3'd2,
      OP_LOCK      = 3'd3,
      OP_CLEAR     = 3'd4
   } req_op_e;

   typedef enum logic {
      NORMAL  = 1'b0,
      LOCKOUT = 1'b1
   } viol_state_e;

   localparam int unsigned PRIV_TID = 0;

endpackage

// File: rtl/secure_reg_bank_if.sv
// rtl/secure_reg_bank_if.sv - thread-tagged request/response bus of the secure register bank
interface secure_reg_bank_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 3,
   parameter int TID_WIDTH  = 4,
   parameter int VIOL_WIDTH = 8
);
   logic                  req_valid;
   logic [2:0]            req_op;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [TID_WIDTH-1:0]  req_tid;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;
   logic                  lockout;
   logic [VIOL_WIDTH-1:0] viol_count;

   modport master (
      output req_valid, req_op, req_addr, req_wdata, req_tid,
      input  rsp_valid, rsp_rdata, rsp_err, lockout, viol_count
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, req_tid,
      output rsp_valid, rsp_rdata, rsp_err, lockout, viol_count
   );
endinterface

// File: rtl/secure_viol_monitor.sv
// rtl/secure_viol_monitor.sv - saturating violation counter and NORMAL/LOCKOUT FSM
module secure_viol_monitor
   import secure_reg_pkg::*;
#(
   parameter int VIOL_WIDTH     = 8,
   parameter int LOCKOUT_THRESH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  viol,
   input  logic                  clear,
   output logic [VIOL_WIDTH-1:0] count,
   output logic                  lockout
);
   viol_state_e           state_q, state_d;
   logic [VIOL_WIDTH-1:0] count_q, count_d, count_inc;
   logic                  lockout_q;

   always_comb begin
      count_inc = (&count_q) ? count_q : count_q + VIOL_WIDTH'(1);
      count_d   = count_q;
      state_d   = state_q;
      if (clear) begin
         count_d = '0;
         state_d = NORMAL;
      end else if (viol) begin
         count_d = count_inc;
         // threshold is judged on the post-increment (saturated) count
         if (LOCKOUT_THRESH != 0 && 32'(count_inc) >= 32'(LOCKOUT_THRESH)) begin
            state_d = LOCKOUT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= NORMAL;
         count_q   <= '0;
         lockout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         lockout_q <= (state_d == LOCKOUT);
      end
   end

   assign count   = count_q;
   assign lockout = lockout_q;
endmodule

// File: rtl/secure_reg_bank.sv
// rtl/secure_reg_bank.sv - thread-owned lockable register bank with access checking
module secure_reg_bank
   import secure_reg_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_REGS       = 8,
   parameter int TID_WIDTH      = 4,
   parameter int VIOL_WIDTH     = 8,
   parameter int LOCKOUT_THRESH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   secure_reg_bank_if.slave   bus
);
   localparam int ADDR_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic [DATA_WIDTH-1:0] regs_q  [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d  [NUM_REGS];
   logic [TID_WIDTH-1:0]  owner_q [NUM_REGS];
   logic [TID_WIDTH-1:0]  owner_d [NUM_REGS];
   logic                  lock_q  [NUM_REGS];
   logic                  lock_d  [NUM_REGS];

   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_err_q, rsp_err_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

   logic                  in_range, priv, is_owner, grant, viol, clear, lockout;
   logic [ADDR_WIDTH-1:0] addr_idx;
   logic [VIOL_WIDTH-1:0] viol_count;

   always_comb begin
      in_range = (32'(bus.req_addr) < 32'(NUM_REGS));
      // out-of-range addresses never index the arrays; they are denied anyway
      addr_idx = in_range ? bus.req_addr : '0;
      priv     = (bus.req_tid == TID_WIDTH'(PRIV_TID));
      is_owner = (bus.req_tid == owner_q[addr_idx]);

      case (bus.req_op)
         OP_READ:      grant = in_range && (priv || is_owner);
         OP_WRITE:     grant = in_range && (priv || is_owner) && !lock_q[addr_idx];
         OP_SET_OWNER: grant = in_range && priv && !lock_q[addr_idx];
         OP_LOCK:      grant = in_range && priv;
         OP_CLEAR:     grant = priv;
         default:      grant = 1'b0;
      endcase
      if (lockout && !priv) grant = 1'b0;

      viol  = bus.req_valid && !grant;
      clear = bus.req_valid && grant && (bus.req_op == OP_CLEAR);

      regs_d  = regs_q;
      owner_d = owner_q;
      lock_d  = lock_q;
      if (bus.req_valid && grant) begin
         case (bus.req_op)
            OP_WRITE:     regs_d[addr_idx]  = bus.req_wdata;
            OP_SET_OWNER: owner_d[addr_idx] = bus.req_wdata[TID_WIDTH-1:0];
            OP_LOCK:      lock_d[addr_idx]  = 1'b1;
            default:      ;
         endcase
      end

      rsp_valid_d = bus.req_valid;
      rsp_err_d   = viol;
      rsp_rdata_d = (bus.req_valid && grant && bus.req_op == OP_READ) ? regs_q[addr_idx] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i]  <= '0;
            owner_q[i] <= '0;
            lock_q[i]  <= 1'b0;
         end
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         regs_q      <= regs_d;
         owner_q     <= owner_d;
         lock_q      <= lock_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   secure_viol_monitor #(
      .VIOL_WIDTH     (VIOL_WIDTH),
      .LOCKOUT_THRESH (LOCKOUT_THRESH)
   ) u_viol_monitor (
      .clk     (clk),
      .rst_n   (rst_n),
      .viol    (viol),
      .clear   (clear),
      .count   (viol_count),
      .lockout (lockout)
   );

   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.rsp_rdata  = rsp_rdata_q;
   assign bus.lockout    = lockout;
   assign bus.viol_count = viol_count;
endmodule

// File: tb/tb_secure_reg_bank.sv
// tb/tb_secure_reg_bank.sv - table-driven bench for the secure register bank (two configurations)
module tb_secure_reg_bank;
   import secure_reg_pkg::*;

   logic clk;
   logic rst_n;

   secure_reg_bank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .TID_WIDTH(4), .VIOL_WIDTH(8)) bus_a ();
   secure_reg_bank_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .TID_WIDTH(4), .VIOL_WIDTH(2)) bus_b ();

   secure_reg_bank #(
      .DATA_WIDTH(32), .NUM_REGS(8), .TID_WIDTH(4), .VIOL_WIDTH(8), .LOCKOUT_THRESH(4)
   ) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   secure_reg_bank #(
      .DATA_WIDTH(32), .NUM_REGS(6), .TID_WIDTH(4), .VIOL_WIDTH(2), .LOCKOUT_THRESH(0)
   ) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   typedef struct {
      logic        sel;
      logic [2:0]  op;
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  tid;
      logic        err;
      logic [31:0] rdata;
      logic [7:0]  viol;
      logic        lock;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t mk(logic sel, logic [2:0] op, logic [2:0] addr, logic [31:0] wdata,
                               logic [3:0] tid, logic err, logic [31:0] rdata, logic [7:0] viol,
                               logic lock);
      vec_t v;
      v.sel = sel; v.op = op; v.addr = addr; v.wdata = wdata; v.tid = tid;
      v.err = err; v.rdata = rdata; v.viol = viol; v.lock = lock;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus_a.req_valid = 1'b0; bus_a.req_op = 3'd0; bus_a.req_addr = 3'd0;
      bus_a.req_wdata = 32'd0; bus_a.req_tid = 4'd0;
      bus_b.req_valid = 1'b0; bus_b.req_op = 3'd0; bus_b.req_addr = 3'd0;
      bus_b.req_wdata = 32'd0; bus_b.req_tid = 4'd0;
   endtask

   // drives one request, waits for the response edge, samples 1 time unit later
   task automatic run_vec(input vec_t v, input string tag);
      idle();
      if (v.sel == 1'b0) begin
         bus_a.req_valid = 1'b1; bus_a.req_op = v.op; bus_a.req_addr = v.addr;
         bus_a.req_wdata = v.wdata; bus_a.req_tid = v.tid;
      end else begin
         bus_b.req_valid = 1'b1; bus_b.req_op = v.op; bus_b.req_addr = v.addr;
         bus_b.req_wdata = v.wdata; bus_b.req_tid = v.tid;
      end
      @(posedge clk);
      #1;
      if (v.sel == 1'b0) begin
         check({tag, " rsp_valid"},  32'(bus_a.rsp_valid),  32'd1);
         check({tag, " rsp_err"},    32'(bus_a.rsp_err),    32'(v.err));
         check({tag, " rsp_rdata"},  bus_a.rsp_rdata,       v.rdata);
         check({tag, " viol_count"}, 32'(bus_a.viol_count), 32'(v.viol));
         check({tag, " lockout"},    32'(bus_a.lockout),    32'(v.lock));
      end else begin
         check({tag, " rsp_valid"},  32'(bus_b.rsp_valid),  32'd1);
         check({tag, " rsp_err"},    32'(bus_b.rsp_err),    32'(v.err));
         check({tag, " rsp_rdata"},  bus_b.rsp_rdata,       v.rdata);
         check({tag, " viol_count"}, 32'(bus_b.viol_count), 32'(v.viol));
         check({tag, " lockout"},    32'(bus_b.lockout),    32'(v.lock));
      end
   endtask

   initial begin
      //                sel  op            addr  wdata         tid   err   rdata         viol  lock
      vecs.push_back(mk(0, OP_READ,      3'd3, 32'h0,        4'd0, 1'b0, 32'h0,        8'd0, 1'b0));
      vecs.push_back(mk(0, OP_SET_OWNER, 3'd2, 32'h5,        4'd0, 1'b0, 32'h0,        8'd0, 1'b0));
      vecs.push_back(mk(0, OP_WRITE,     3'd2, 32'hCAFEF00D, 4'd5, 1'b0, 32'h0,        8'd0, 1'b0));
      vecs.push_back(mk(0, OP_READ,      3'd2, 32'h0,        4'd5, 1'b0, 32'hCAFEF00D, 8'd0, 1'b0));
      vecs.push_back(mk(0, OP_READ,      3'd2, 32'h0,        4'd6, 1'b1, 32'h0,        8'd1, 1'b0));
      vecs.push_back(mk(0, OP_LOCK,      3'd2, 32'h0,        4'd0, 1'b0, 32'h0,        8'd1, 1'b0));
      vecs.push_back(mk(0, OP_WRITE,     3'd2, 32'h12345678, 4'd5, 1'b1, 32'h0,        8'd2, 1'b0));
      vecs.push_back(mk(0, OP_SET_OWNER, 3'd2, 32'h6,        4'd0, 1'b1, 32'h0,        8'd3, 1'b0));
      vecs.push_back(mk(0, OP_READ,      3'd2, 32'h0,        4'd5, 1'b0, 32'hCAFEF00D, 8'd3, 1'b0));
      vecs.push_back(mk(0, OP_CLEAR,     3'd0, 32'h0,        4'd0, 1'b0, 32'h0,        8'd0, 1'b0));
      vecs.push_back(mk(0, OP_READ,      3'd2, 32'h0,        4'd7, 1'b1, 32'h0,        8'd1, 1'b0));
      vecs.push_back(mk(0, OP_READ,      3'd2, 32'h0,        4'd7, 1'b1, 32'h0,        8'd2, 1'b0));
      vecs.push_back(mk(0, OP_READ,      3'd2, 32'h0,        4'd7, 1'b1, 32'h0,        8'd3, 1'b0));
      vecs.push_back(mk(0, OP_READ,      3'd2, 32'h0,        4'd7, 1'b1, 32'h0,        8'd4, 1'b1));
      vecs.push_back(mk(0, OP_READ,      3'd2, 32'h0,        4'd5, 1'b1, 32'h0,        8'd5, 1'b1));
      vecs.push_back(mk(0, OP_LOCK,      3'd2, 32'h0,        4'd0, 1'b0, 32'h0,        8'd5, 1'b1));
      vecs.push_back(mk(0, OP_CLEAR,     3'd7, 32'h0,        4'd0, 1'b0, 32'h0,        8'd0, 1'b0));
      vecs.push_back(mk(0, OP_READ,      3'd2, 32'h0,        4'd5, 1'b0, 32'hCAFEF00D, 8'd0, 1'b0));
      vecs.push_back(mk(0, OP_LOCK,      3'd3, 32'h0,        4'd0, 1'b0, 32'h0,        8'd0, 1'b0));
      vecs.push_back(mk(0, OP_WRITE,     3'd3, 32'h11111111, 4'd0, 1'b1, 32'h0,        8'd1, 1'b0));
      vecs.push_back(mk(0, 3'd5,         3'd0, 32'h0,        4'd0, 1'b1, 32'h0,        8'd2, 1'b0));
      vecs.push_back(mk(0, 3'd6,         3'd3, 32'h22222222, 4'd0, 1'b1, 32'h0,        8'd3, 1'b0));
      vecs.push_back(mk(0, OP_READ,      3'd3, 32'h0,        4'd0, 1'b0, 32'h0,        8'd3, 1'b0));
      // second bank: 6 entries, 2-bit counter, lockout disabled
      vecs.push_back(mk(1, OP_WRITE,     3'd1, 32'h55,       4'd0, 1'b0, 32'h0,        8'd0, 1'b0));
      vecs.push_back(mk(1, 3'd6,         3'd1, 32'h0,        4'd0, 1'b1, 32'h0,        8'd1, 1'b0));
      vecs.push_back(mk(1, OP_WRITE,     3'd6, 32'h77,       4'd0, 1'b1, 32'h0,        8'd2, 1'b0));
      vecs.push_back(mk(1, OP_READ,      3'd1, 32'h0,        4'd0, 1'b0, 32'h55,       8'd2, 1'b0));
      vecs.push_back(mk(1, OP_READ,      3'd6, 32'h0,        4'd0, 1'b1, 32'h0,        8'd3, 1'b0));
      vecs.push_back(mk(1, OP_READ,      3'd1, 32'h0,        4'd3, 1'b1, 32'h0,        8'd3, 1'b0));
      vecs.push_back(mk(1, 3'd7,         3'd0, 32'h0,        4'd0, 1'b1, 32'h0,        8'd3, 1'b0));

      rst_n = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      check("reset a rsp_valid",  32'(bus_a.rsp_valid),  32'd0);
      check("reset a viol_count", 32'(bus_a.viol_count), 32'd0);
      check("reset a lockout",    32'(bus_a.lockout),    32'd0);
      check("reset b rsp_valid",  32'(bus_b.rsp_valid),  32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         run_vec(vecs[i], $sformatf("v%0d", i));
      end

      idle();
      @(posedge clk);
      #1;
      check("rsp_valid single cycle", 32'(bus_a.rsp_valid), 32'd0);

      // write accepted, then reset asserted the cycle after: response and all state cleared
      run_vec(mk(0, OP_WRITE, 3'd1, 32'hAAAA5555, 4'd0, 1'b0, 32'h0, 8'd3, 1'b0), "pre_rst write");
      bus_a.req_valid = 1'b1; bus_a.req_op = OP_READ; bus_a.req_addr = 3'd1;
      rst_n = 1'b0;
      #1;
      check("midrst rsp_valid",  32'(bus_a.rsp_valid),  32'd0);
      check("midrst rsp_err",    32'(bus_a.rsp_err),    32'd0);
      check("midrst viol_count", 32'(bus_a.viol_count), 32'd0);
      check("midrst lockout",    32'(bus_a.lockout),    32'd0);
      idle();
      @(posedge clk);
      #1;
      check("in reset rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
      rst_n = 1'b1;
      run_vec(mk(0, OP_READ,  3'd1, 32'h0,        4'd0, 1'b0, 32'h0, 8'd0, 1'b0), "post_rst read a1");
      run_vec(mk(0, OP_READ,  3'd2, 32'h0,        4'd5, 1'b1, 32'h0, 8'd1, 1'b0), "post_rst owner a2");
      run_vec(mk(0, OP_WRITE, 3'd3, 32'h33333333, 4'd0, 1'b0, 32'h0, 8'd1, 1'b0), "post_rst unlock a3");
      run_vec(mk(0, OP_READ,  3'd3, 32'h0,        4'd0, 1'b0, 32'h33333333, 8'd1, 1'b0), "post_rst read a3");
      idle();
      @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
